// File: rtl/reg_mng_rename_if.sv
// Decoder/ROB-facing bundle of the rename manager: decode group, rename results,
// ROB allocation, completion broadcasts and commit.
interface reg_mng_rename_if #(
  parameter int AREG_W    = 5,
  parameter int ROB_IDX_W = 5,
  parameter int WAYS      = 2,
  parameter int NUM_BC    = 2
);
  logic                      flush;
  logic [WAYS-1:0]           dec_valid;
  logic [WAYS-1:0]           dec_rd_we;
  logic [WAYS*AREG_W-1:0]    dec_rd;
  logic [WAYS*AREG_W-1:0]    dec_rs1;
  logic [WAYS*AREG_W-1:0]    dec_rs2;
  logic                      dec_ready;
  logic                      rob_space;
  logic [ROB_IDX_W-1:0]      rob_tail;
  logic [WAYS-1:0]           rob_alloc;
  logic [WAYS-1:0]           ren_valid;
  logic [WAYS-1:0]           ren_s1_map;
  logic [WAYS-1:0]           ren_s2_map;
  logic [WAYS*ROB_IDX_W-1:0] ren_s1_tag;
  logic [WAYS*ROB_IDX_W-1:0] ren_s2_tag;
  logic [WAYS-1:0]           ren_s1_done;
  logic [WAYS-1:0]           ren_s2_done;
  logic [WAYS*ROB_IDX_W-1:0] ren_tag;
  logic [NUM_BC-1:0]         bc_valid;
  logic [NUM_BC*ROB_IDX_W-1:0] bc_tag;
  logic                      cmt_valid;
  logic [AREG_W-1:0]         cmt_rd;
  logic [ROB_IDX_W-1:0]      cmt_tag;

  modport master (
    output flush, dec_valid, dec_rd_we, dec_rd, dec_rs1, dec_rs2,
    output rob_space, rob_tail, bc_valid, bc_tag, cmt_valid, cmt_rd, cmt_tag,
    input  dec_ready, rob_alloc, ren_valid, ren_s1_map, ren_s2_map,
    input  ren_s1_tag, ren_s2_tag, ren_s1_done, ren_s2_done, ren_tag
  );

  modport slave (
    input  flush, dec_valid, dec_rd_we, dec_rd, dec_rs1, dec_rs2,
    input  rob_space, rob_tail, bc_valid, bc_tag, cmt_valid, cmt_rd, cmt_tag,
    output dec_ready, rob_alloc, ren_valid, ren_s1_map, ren_s2_map,
    output ren_s1_tag, ren_s2_tag, ren_s1_done, ren_s2_done, ren_tag
  );
endinterface

// File: rtl/reg_mng_rename.sv
// Multi-way register rename/status manager: maps destination aregs to ROB tags,
// resolves intra-group dependencies and tracks completion/commit per areg.
module reg_mng_rename #(
  parameter int NUM_AREG  = 32,
  parameter int AREG_W    = 5,
  parameter int ROB_IDX_W = 5,
  parameter int WAYS      = 2,
  parameter int NUM_BC    = 2,
  parameter int ZERO_REG  = 1
) (
  input logic             clk,
  input logic             rst,
  reg_mng_rename_if.slave bus
);
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef struct packed {
    logic                 map;
    logic [ROB_IDX_W-1:0] tag;
    logic                 done;
  } look_t;

  state_t            state_reg;
  logic [AREG_W-1:0] clr_idx_reg;
  logic              dec_ready_reg;

  logic                 mapped_reg  [NUM_AREG];
  logic [ROB_IDX_W-1:0] tag_reg     [NUM_AREG];
  logic                 done_reg    [NUM_AREG];
  logic                 mapped_next [NUM_AREG];
  logic [ROB_IDX_W-1:0] tag_next    [NUM_AREG];
  logic                 done_next   [NUM_AREG];

  logic [AREG_W-1:0]    slot_rd  [WAYS];
  logic [AREG_W-1:0]    slot_rs1 [WAYS];
  logic [AREG_W-1:0]    slot_rs2 [WAYS];
  logic [ROB_IDX_W-1:0] slot_tag [WAYS];
  logic [WAYS-1:0]      slot_wr;
  look_t                look_s1  [WAYS];
  look_t                look_s2  [WAYS];
  logic [ROB_IDX_W-1:0] bc_tag_w [NUM_BC];
  logic [NUM_BC-1:0]    bc_valid_w;
  logic                 fire;
  logic                 renamed;

  logic [WAYS-1:0]           ren_valid_reg, ren_s1_map_reg, ren_s2_map_reg;
  logic [WAYS-1:0]           ren_s1_done_reg, ren_s2_done_reg;
  logic [WAYS*ROB_IDX_W-1:0] ren_s1_tag_reg, ren_s2_tag_reg, ren_tag_reg;

  assign bc_valid_w = bus.bc_valid;
  assign fire = (state_reg == ST_RUN) & (|bus.dec_valid) & bus.rob_space & ~bus.flush;

  function automatic logic bc_hit(input logic [ROB_IDX_W-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < NUM_BC; b++) hit = hit | (bc_valid_w[b] & (bc_tag_w[b] == t));
    return hit;
  endfunction

  // Later producers in the group shadow earlier ones and the table; r0 is never mapped.
  function automatic look_t lookup(input logic [AREG_W-1:0] src, input int slot);
    look_t r;
    r.map  = mapped_reg[src];
    r.tag  = tag_reg[src];
    r.done = done_reg[src] | bc_hit(tag_reg[src]);
    for (int i = 0; i < WAYS; i++) begin
      if (i < slot && slot_wr[i] && slot_rd[i] == src) begin
        r.map  = 1'b1;
        r.tag  = slot_tag[i];
        r.done = 1'b0;
      end
    end
    if (ZERO_REG != 0 && src == '0) r = '0;
    return r;
  endfunction

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_slot
      assign slot_rd[gi]  = bus.dec_rd[gi*AREG_W +: AREG_W];
      assign slot_rs1[gi] = bus.dec_rs1[gi*AREG_W +: AREG_W];
      assign slot_rs2[gi] = bus.dec_rs2[gi*AREG_W +: AREG_W];
      assign slot_tag[gi] = bus.rob_tail + ROB_IDX_W'(gi);
      assign slot_wr[gi]  = bus.dec_valid[gi] & bus.dec_rd_we[gi] &
                            ~((ZERO_REG != 0) & (slot_rd[gi] == '0));
      assign look_s1[gi]  = lookup(slot_rs1[gi], gi);
      assign look_s2[gi]  = lookup(slot_rs2[gi], gi);
    end
    for (genvar gi = 0; gi < NUM_BC; gi++) begin : g_bc
      assign bc_tag_w[gi] = bus.bc_tag[gi*ROB_IDX_W +: ROB_IDX_W];
    end
  endgenerate

  always_comb begin
    mapped_next = mapped_reg;
    tag_next    = tag_reg;
    done_next   = done_reg;
    renamed     = 1'b0;
    if (state_reg == ST_CLEAR) begin
      mapped_next[clr_idx_reg] = 1'b0;
      tag_next[clr_idx_reg]    = '0;
      done_next[clr_idx_reg]   = 1'b0;
    end else if (!bus.flush) begin
      for (int r = 0; r < NUM_AREG; r++) begin
        renamed = 1'b0;
        // Ascending scan so the highest slot writing this areg wins.
        for (int i = 0; i < WAYS; i++) begin
          if (fire && slot_wr[i] && slot_rd[i] == AREG_W'(r)) begin
            renamed     = 1'b1;
            tag_next[r] = slot_tag[i];
          end
        end
        if (renamed) begin
          mapped_next[r] = 1'b1;
          done_next[r]   = 1'b0;
        end else begin
          if (mapped_reg[r] && bc_hit(tag_reg[r])) done_next[r] = 1'b1;
          if (bus.cmt_valid && bus.cmt_rd == AREG_W'(r) && mapped_reg[r] &&
              tag_reg[r] == bus.cmt_tag)
            mapped_next[r] = 1'b0;
        end
      end
    end
  end

  // Table contents need no reset: the CLEAR sweep zeroes every entry before use.
  always_ff @(posedge clk) begin
    mapped_reg <= mapped_next;
    tag_reg    <= tag_next;
    done_reg   <= done_next;
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      state_reg     <= ST_CLEAR;
      clr_idx_reg   <= '0;
      dec_ready_reg <= 1'b0;
    end else if (state_reg == ST_CLEAR) begin
      clr_idx_reg <= clr_idx_reg + AREG_W'(1);
      if (clr_idx_reg == AREG_W'(NUM_AREG - 1)) begin
        state_reg     <= ST_RUN;
        dec_ready_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ren_valid_reg   <= '0;
      ren_s1_map_reg  <= '0;
      ren_s2_map_reg  <= '0;
      ren_s1_done_reg <= '0;
      ren_s2_done_reg <= '0;
      ren_s1_tag_reg  <= '0;
      ren_s2_tag_reg  <= '0;
      ren_tag_reg     <= '0;
    end else begin
      ren_valid_reg <= fire ? bus.dec_valid : '0;
      for (int i = 0; i < WAYS; i++) begin
        ren_s1_map_reg[i]  <= fire & look_s1[i].map;
        ren_s2_map_reg[i]  <= fire & look_s2[i].map;
        ren_s1_done_reg[i] <= fire & look_s1[i].done;
        ren_s2_done_reg[i] <= fire & look_s2[i].done;
        ren_s1_tag_reg[i*ROB_IDX_W +: ROB_IDX_W] <= fire ? look_s1[i].tag : '0;
        ren_s2_tag_reg[i*ROB_IDX_W +: ROB_IDX_W] <= fire ? look_s2[i].tag : '0;
        ren_tag_reg[i*ROB_IDX_W +: ROB_IDX_W]    <= fire ? slot_tag[i] : '0;
      end
    end
  end

  assign bus.dec_ready   = dec_ready_reg;
  assign bus.rob_alloc   = fire ? bus.dec_valid : '0;
  assign bus.ren_valid   = ren_valid_reg;
  assign bus.ren_s1_map  = ren_s1_map_reg;
  assign bus.ren_s2_map  = ren_s2_map_reg;
  assign bus.ren_s1_done = ren_s1_done_reg;
  assign bus.ren_s2_done = ren_s2_done_reg;
  assign bus.ren_s1_tag  = ren_s1_tag_reg;
  assign bus.ren_s2_tag  = ren_s2_tag_reg;
  assign bus.ren_tag     = ren_tag_reg;
endmodule

// File: tb/tb_reg_mng_rename.sv
// Bench for reg_mng_rename: directed vector table, hand sequences for clear/flush,
// then random traffic against an areg-level reference model.
module tb_reg_mng_rename;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_mng_rename_if #(.AREG_W(5), .ROB_IDX_W(5), .WAYS(2), .NUM_BC(2)) bus ();

  reg_mng_rename #(
    .NUM_AREG(32), .AREG_W(5), .ROB_IDX_W(5), .WAYS(2), .NUM_BC(2), .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: per-areg status plus remaining clear cycles.
  bit m_map  [32];
  int m_tag  [32];
  bit m_done [32];
  int m_clear_left;

  typedef struct packed {
    logic [1:0] valid, we;
    logic [4:0] rd0, rd1, rs1_0, rs1_1, rs2_0, rs2_1, tail;
    logic       stall;
    logic [1:0] bcv;
    logic [4:0] bct0, bct1;
    logic       cmtv;
    logic [4:0] cmt_rd, cmt_tag;
    logic [1:0] e_alloc;
    logic [4:0] e_tag0, e_tag1;
    logic       chk_slot, chk_rs2, e_map;
    logic [4:0] e_stag;
    logic       e_done;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 32; r++) begin
      m_map[r] = 1'b0; m_tag[r] = 0; m_done[r] = 1'b0;
    end
  endfunction

  function automatic bit bc_match(input int t);
    for (int b = 0; b < 2; b++)
      if (bus.bc_valid[b] && int'(bus.bc_tag[b*5 +: 5]) == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rd_of(input int i);
    return int'(bus.dec_rd[i*5 +: 5]);
  endfunction

  function automatic void model_lookup(input int j, input int s, output bit mp, output int tg,
                                       output bit dn);
    int src;
    src = (s == 0) ? int'(bus.dec_rs1[j*5 +: 5]) : int'(bus.dec_rs2[j*5 +: 5]);
    mp = 1'b0; tg = 0; dn = 1'b0;
    if (src == 0) return;
    for (int i = j - 1; i >= 0; i--) begin
      if (bus.dec_valid[i] && bus.dec_rd_we[i] && rd_of(i) == src) begin
        mp = 1'b1; tg = (int'(bus.rob_tail) + i) % 32;
        return;
      end
    end
    mp = m_map[src]; tg = m_tag[src]; dn = m_done[src] || bc_match(m_tag[src]);
  endfunction

  function automatic void model_update(input bit fire);
    bit ren [32];
    int c;
    if (bus.flush) begin
      model_clear();
      m_clear_left = 32;
      return;
    end
    if (m_clear_left > 0) begin
      m_clear_left--;
      return;
    end
    for (int r = 0; r < 32; r++) ren[r] = 1'b0;
    if (fire) begin
      for (int i = 0; i < 2; i++) begin
        if (bus.dec_valid[i] && bus.dec_rd_we[i] && rd_of(i) != 0) begin
          m_map[rd_of(i)] = 1'b1; m_tag[rd_of(i)] = (int'(bus.rob_tail) + i) % 32;
          m_done[rd_of(i)] = 1'b0; ren[rd_of(i)] = 1'b1;
        end
      end
    end
    for (int r = 0; r < 32; r++)
      if (!ren[r] && m_map[r] && bc_match(m_tag[r])) m_done[r] = 1'b1;
    c = int'(bus.cmt_rd);
    if (bus.cmt_valid && !ren[c] && m_map[c] && m_tag[c] == int'(bus.cmt_tag)) m_map[c] = 1'b0;
  endfunction

  // One clock: checks combinational outputs mid-cycle, registered outputs after the edge.
  task automatic cycle(output bit fired, output int alloc_seen);
    bit exp_ready, fire;
    int exp_alloc, tail, am, at, ad;
    bit pm [2][2];
    int pt [2][2];
    bit pd [2][2];
    #4;
    exp_ready = (m_clear_left == 0);
    chk("dec_ready", int'(bus.dec_ready), int'(exp_ready));
    fire = exp_ready && (bus.dec_valid != 2'b00) && bus.rob_space && !bus.flush;
    exp_alloc = fire ? int'(bus.dec_valid) : 0;
    alloc_seen = int'(bus.rob_alloc);
    chk("rob_alloc", int'(bus.rob_alloc), exp_alloc);
    tail = int'(bus.rob_tail);
    for (int j = 0; j < 2; j++)
      for (int s = 0; s < 2; s++) model_lookup(j, s, pm[j][s], pt[j][s], pd[j][s]);
    model_update(fire);
    @(posedge clk);
    #1;
    chk("ren_valid", int'(bus.ren_valid), exp_alloc);
    for (int j = 0; j < 2; j++) begin
      if (exp_alloc[j]) begin
        chk($sformatf("ren_tag slot%0d", j), int'(bus.ren_tag[j*5 +: 5]), (tail + j) % 32);
        for (int s = 0; s < 2; s++) begin
          am = (s == 0) ? int'(bus.ren_s1_map[j])  : int'(bus.ren_s2_map[j]);
          at = (s == 0) ? int'(bus.ren_s1_tag[j*5 +: 5]) : int'(bus.ren_s2_tag[j*5 +: 5]);
          ad = (s == 0) ? int'(bus.ren_s1_done[j]) : int'(bus.ren_s2_done[j]);
          chk($sformatf("s%0d_map slot%0d", s + 1, j), am, int'(pm[j][s]));
          if (pm[j][s]) begin
            chk($sformatf("s%0d_tag slot%0d", s + 1, j), at, pt[j][s]);
            chk($sformatf("s%0d_done slot%0d", s + 1, j), ad, int'(pd[j][s]));
          end
        end
      end
    end
    fired = fire;
  endtask

  task automatic set_idle();
    bus.flush = 1'b0; bus.dec_valid = '0; bus.dec_rd_we = '0;
    bus.dec_rd = '0; bus.dec_rs1 = '0; bus.dec_rs2 = '0;
    bus.rob_space = 1'b1; bus.rob_tail = '0;
    bus.bc_valid = '0; bus.bc_tag = '0;
    bus.cmt_valid = 1'b0; bus.cmt_rd = '0; bus.cmt_tag = '0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    bit f;
    int a;
    n = 0;
    while (bus.dec_ready !== 1'b1 && n < 100) begin
      cycle(f, a);
      n++;
    end
    chk(name, n, 32);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    bit f;
    int a, s, am, at, ad, tail_cnt, n;
    vec_t v;

    vecs[0]  = '{valid:2'b11, rs1_0:5'd5, rs1_1:5'd5, tail:5'd0, e_alloc:2'b11,
                 e_tag0:5'd0, e_tag1:5'd1, default:'0};
    vecs[1]  = '{valid:2'b11, we:2'b01, rd0:5'd7, rs1_1:5'd7, tail:5'd3, e_alloc:2'b11,
                 e_tag0:5'd3, e_tag1:5'd4, chk_slot:1'b1, e_map:1'b1, e_stag:5'd3, default:'0};
    vecs[2]  = '{valid:2'b01, rs2_0:5'd7, tail:5'd5, e_alloc:2'b01, e_tag0:5'd5,
                 chk_rs2:1'b1, e_map:1'b1, e_stag:5'd3, default:'0};
    vecs[3]  = '{valid:2'b11, we:2'b11, rd0:5'd4, rd1:5'd4, rs1_0:5'd4, tail:5'd31,
                 e_alloc:2'b11, e_tag0:5'd31, e_tag1:5'd0, default:'0};
    vecs[4]  = '{valid:2'b01, rs1_0:5'd4, tail:5'd1, e_alloc:2'b01, e_tag0:5'd1,
                 e_map:1'b1, e_stag:5'd0, default:'0};
    vecs[5]  = '{valid:2'b01, we:2'b01, rd0:5'd9, rs1_0:5'd7, tail:5'd6, e_alloc:2'b01,
                 e_tag0:5'd6, e_map:1'b1, e_stag:5'd3, default:'0};
    vecs[6]  = '{valid:2'b01, rs1_0:5'd9, tail:5'd7, bcv:2'b01, bct0:5'd6, e_alloc:2'b01,
                 e_tag0:5'd7, e_map:1'b1, e_stag:5'd6, e_done:1'b1, default:'0};
    vecs[7]  = '{valid:2'b01, rs1_0:5'd9, tail:5'd8, e_alloc:2'b01, e_tag0:5'd8,
                 e_map:1'b1, e_stag:5'd6, e_done:1'b1, default:'0};
    vecs[8]  = '{valid:2'b01, we:2'b01, rd0:5'd9, rs1_0:5'd4, tail:5'd10, cmtv:1'b1,
                 cmt_rd:5'd9, cmt_tag:5'd6, e_alloc:2'b01, e_tag0:5'd10, e_map:1'b1,
                 e_stag:5'd0, default:'0};
    vecs[9]  = '{valid:2'b01, rs1_0:5'd9, tail:5'd11, cmtv:1'b1, cmt_rd:5'd9, cmt_tag:5'd5,
                 e_alloc:2'b01, e_tag0:5'd11, e_map:1'b1, e_stag:5'd10, default:'0};
    vecs[10] = '{valid:2'b01, rs1_0:5'd9, tail:5'd12, e_alloc:2'b01, e_tag0:5'd12,
                 e_map:1'b1, e_stag:5'd10, default:'0};
    vecs[11] = '{cmtv:1'b1, cmt_rd:5'd9, cmt_tag:5'd10, tail:5'd13, default:'0};
    vecs[12] = '{valid:2'b01, rs1_0:5'd9, tail:5'd13, e_alloc:2'b01, e_tag0:5'd13,
                 default:'0};
    vecs[13] = '{valid:2'b11, we:2'b01, rd0:5'd0, rs1_1:5'd0, tail:5'd14, e_alloc:2'b11,
                 e_tag0:5'd14, e_tag1:5'd15, chk_slot:1'b1, default:'0};
    vecs[14] = '{valid:2'b11, we:2'b11, rd0:5'd5, rd1:5'd5, tail:5'd16, stall:1'b1,
                 default:'0};
    vecs[15] = '{valid:2'b01, we:2'b01, rd0:5'd3, rs1_0:5'd3, tail:5'd16, e_alloc:2'b01,
                 e_tag0:5'd16, default:'0};
    vecs[16] = '{valid:2'b11, we:2'b11, rd0:5'd3, rd1:5'd3, rs2_1:5'd3, tail:5'd17,
                 e_alloc:2'b11, e_tag0:5'd17, e_tag1:5'd18, chk_slot:1'b1, chk_rs2:1'b1,
                 e_map:1'b1, e_stag:5'd17, default:'0};
    vecs[17] = '{valid:2'b01, rs1_0:5'd3, tail:5'd19, bcv:2'b10, bct1:5'd18,
                 e_alloc:2'b01, e_tag0:5'd19, e_map:1'b1, e_stag:5'd18, e_done:1'b1,
                 default:'0};
    vecs[18] = '{valid:2'b01, rs1_0:5'd5, tail:5'd20, e_alloc:2'b01, e_tag0:5'd20,
                 default:'0};

    // Reset: outputs low, then exactly 32 clear cycles before dec_ready.
    set_idle();
    bus.dec_valid = 2'b11;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ren_valid", int'(bus.ren_valid), 0);
    chk("rst_rob_alloc", int'(bus.rob_alloc), 0);
    chk("rst_dec_ready", int'(bus.dec_ready), 0);
    rst = 1'b0;
    model_clear();
    m_clear_left = 32;
    wait_ready("reset_clear_len");

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      set_idle();
      bus.dec_valid = v.valid; bus.dec_rd_we = v.we;
      bus.dec_rd = {v.rd1, v.rd0}; bus.dec_rs1 = {v.rs1_1, v.rs1_0};
      bus.dec_rs2 = {v.rs2_1, v.rs2_0}; bus.rob_tail = v.tail; bus.rob_space = !v.stall;
      bus.bc_valid = v.bcv; bus.bc_tag = {v.bct1, v.bct0};
      bus.cmt_valid = v.cmtv; bus.cmt_rd = v.cmt_rd; bus.cmt_tag = v.cmt_tag;
      cycle(f, a);
      chk($sformatf("vec%0d_alloc", k), a, int'(v.e_alloc));
      chk($sformatf("vec%0d_ren_valid", k), int'(bus.ren_valid), int'(v.e_alloc));
      if (v.e_alloc[0]) chk($sformatf("vec%0d_tag0", k), int'(bus.ren_tag[4:0]), int'(v.e_tag0));
      if (v.e_alloc[1]) chk($sformatf("vec%0d_tag1", k), int'(bus.ren_tag[9:5]), int'(v.e_tag1));
      s = int'(v.chk_slot);
      if (v.e_alloc[s]) begin
        am = v.chk_rs2 ? int'(bus.ren_s2_map[s]) : int'(bus.ren_s1_map[s]);
        at = v.chk_rs2 ? int'(bus.ren_s2_tag[s*5 +: 5]) : int'(bus.ren_s1_tag[s*5 +: 5]);
        ad = v.chk_rs2 ? int'(bus.ren_s2_done[s]) : int'(bus.ren_s1_done[s]);
        chk($sformatf("vec%0d_map", k), am, int'(v.e_map));
        if (v.e_map) begin
          chk($sformatf("vec%0d_stag", k), at, int'(v.e_stag));
          chk($sformatf("vec%0d_done", k), ad, int'(v.e_done));
        end
      end
    end

    // Flush in RUN with a valid group, then flush again partway through CLEAR.
    set_idle();
    bus.dec_valid = 2'b11; bus.dec_rd_we = 2'b11; bus.dec_rd = {5'd8, 5'd7};
    bus.rob_tail = 5'd21; bus.flush = 1'b1;
    cycle(f, a);
    chk("flush_alloc", a, 0);
    chk("flush_ren_valid", int'(bus.ren_valid), 0);
    bus.flush = 1'b0;
    wait_ready("flush_clear_len");
    bus.flush = 1'b1;
    cycle(f, a);
    bus.flush = 1'b0;
    repeat (10) cycle(f, a);
    bus.flush = 1'b1;
    cycle(f, a);
    bus.flush = 1'b0;
    wait_ready("reflush_clear_len");
    set_idle();
    bus.dec_valid = 2'b01; bus.dec_rs1 = {5'd0, 5'd7}; bus.rob_tail = 5'd21;
    cycle(f, a);
    chk("post_flush_r7_map", int'(bus.ren_s1_map[0]), 0);

    // Random traffic against the reference model.
    tail_cnt = 22;
    for (int k = 0; k < 700; k++) begin
      n = int'($urandom_range(0, 2));
      bus.dec_valid = 2'((1 << n) - 1);
      bus.dec_rd_we = 2'($urandom_range(0, 3));
      bus.dec_rd  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.dec_rs1 = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.dec_rs2 = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.rob_tail = 5'(tail_cnt % 32);
      bus.rob_space = ($urandom_range(0, 9) != 0);
      bus.bc_valid = 2'($urandom_range(0, 3));
      bus.bc_tag = {5'((tail_cnt + 32 - int'($urandom_range(1, 8))) % 32),
                    5'((tail_cnt + 32 - int'($urandom_range(1, 8))) % 32)};
      bus.cmt_valid = ($urandom_range(0, 2) == 0);
      bus.cmt_rd = 5'($urandom_range(0, 7));
      bus.cmt_tag = ($urandom_range(0, 1) == 0) ? 5'(m_tag[int'(bus.cmt_rd)])
                                                : 5'($urandom_range(0, 31));
      bus.flush = ($urandom_range(0, 119) == 0);
      cycle(f, a);
      if (f) tail_cnt = tail_cnt + $countones(a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
